// File: rtl/ws2812_frame_sequencer.sv
// Frame-level controller for the WS2812 byte sender: walks pixel memory, feeds G,R,B bytes, paces frames.
// Optional global brightness scaling when WS2812_SEQ_BRIGHTNESS_EN is defined (adds input brightness).
module ws2812_frame_sequencer #(
   parameter int unsigned NUM_LEDS     = 8,
   parameter int unsigned FRAME_PERIOD = 200000,
   parameter int unsigned ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [23:0]       rd_data,
`ifdef WS2812_SEQ_BRIGHTNESS_EN
   input  logic [7:0]        brightness,
`endif
   output logic              tx_trigger,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_request,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun
);

   localparam int unsigned TMR_W = $clog2(FRAME_PERIOD + 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD     = TMR_W'(FRAME_PERIOD - 1);
   // FETCH and LOAD take two cycles, so the restart is launched while the timer still reads 2
   localparam logic [TMR_W-1:0]  RESTART_LEAD = TMR_W'(2);
   localparam logic [ADDR_W-1:0] LAST_PIX     = ADDR_W'(NUM_LEDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_STREAM,
      S_DRAIN,
      S_WAIT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_rd_en;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_data_vld;
   logic [ADDR_W-1:0] r_pix_idx;
   logic [1:0]        r_byte_idx;
   logic [23:0]       r_pixel;
   logic              r_tx_trigger;
   logic [7:0]        r_tx_data;
   logic              r_tx_valid;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_overrun;
   logic [TMR_W-1:0]  r_timer;

   logic              w_rd_en_nxt;
   logic [ADDR_W-1:0] w_rd_addr_nxt;
   logic [ADDR_W-1:0] w_pix_idx_nxt;
   logic [1:0]        w_byte_idx_nxt;
   logic [23:0]       w_pixel_nxt;
   logic              w_tx_trigger_nxt;
   logic [7:0]        w_tx_data_nxt;
   logic              w_tx_valid_nxt;
   logic              w_busy_nxt;
   logic              w_frame_done_nxt;
   logic              w_overrun_nxt;
   logic [TMR_W-1:0]  w_timer_nxt;

   logic              w_consume;
   logic [23:0]       w_pix_cap;

   assign w_consume = tx_request & r_tx_valid;

`ifdef WS2812_SEQ_BRIGHTNESS_EN
   logic [7:0] r_bright;
   logic [7:0] w_bright;

   function automatic logic [7:0] f_scale(input logic [7:0] b, input logic [7:0] br);
      logic [15:0] prod;
      prod = 16'(b) * (16'(br) + 16'd1);
      return 8'(prod >> 8);
   endfunction

   // Brightness is taken live for pixel 0 and held for the rest of the frame
   assign w_bright  = (r_state == S_LOAD) ? brightness : r_bright;
   assign w_pix_cap = {f_scale(rd_data[23:16], w_bright),
                       f_scale(rd_data[15:8],  w_bright),
                       f_scale(rd_data[7:0],   w_bright)};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bright <= 8'd0;
      end else if (r_state == S_LOAD) begin
         r_bright <= brightness;
      end
   end
`else
   assign w_pix_cap = rd_data;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt      = r_state;
      w_rd_en_nxt      = 1'b0;
      w_rd_addr_nxt    = r_rd_addr;
      w_pix_idx_nxt    = r_pix_idx;
      w_byte_idx_nxt   = r_byte_idx;
      w_pixel_nxt      = r_pixel;
      w_tx_trigger_nxt = 1'b0;
      w_tx_data_nxt    = r_tx_data;
      w_tx_valid_nxt   = r_tx_valid;
      w_frame_done_nxt = 1'b0;
      w_overrun_nxt    = 1'b0;
      w_timer_nxt      = (r_timer != '0) ? r_timer - TMR_W'(1) : '0;

      case (r_state)
         S_IDLE: begin
            w_timer_nxt = r_timer;
            if (enable) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = S_LOAD;
         end
         S_LOAD: begin
            w_pixel_nxt      = w_pix_cap;
            w_tx_data_nxt    = w_pix_cap[15:8];
            w_tx_valid_nxt   = 1'b1;
            w_tx_trigger_nxt = 1'b1;
            w_timer_nxt      = TMR_LOAD;
            w_state_nxt      = S_STREAM;
         end
         S_STREAM: begin
            if (r_data_vld) begin
               w_pixel_nxt    = w_pix_cap;
               w_tx_data_nxt  = w_pix_cap[15:8];
               w_tx_valid_nxt = 1'b1;
            end else if (w_consume) begin
               case (r_byte_idx)
                  2'd0: begin
                     w_tx_data_nxt  = r_pixel[23:16];
                     w_byte_idx_nxt = 2'd1;
                  end
                  2'd1: begin
                     w_tx_data_nxt  = r_pixel[7:0];
                     w_byte_idx_nxt = 2'd2;
                  end
                  default: begin
                     w_tx_valid_nxt = 1'b0;
                     w_byte_idx_nxt = 2'd0;
                     if (r_pix_idx == LAST_PIX) begin
                        w_state_nxt = S_DRAIN;
                     end else begin
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = r_pix_idx + ADDR_W'(1);
                        w_pix_idx_nxt = r_pix_idx + ADDR_W'(1);
                     end
                  end
               endcase
            end
         end
         S_DRAIN: begin
            w_tx_valid_nxt = 1'b0;
            if (tx_request) begin
               w_frame_done_nxt = 1'b1;
               if (r_timer > RESTART_LEAD) begin
                  w_state_nxt = S_WAIT;
               end else begin
                  w_overrun_nxt = (r_timer < RESTART_LEAD);
                  w_state_nxt   = enable ? S_FETCH : S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (r_timer <= RESTART_LEAD) begin
               w_state_nxt = enable ? S_FETCH : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Every frame starts from pixel 0, byte 0
      if (w_state_nxt == S_FETCH) begin
         w_rd_en_nxt    = 1'b1;
         w_rd_addr_nxt  = '0;
         w_pix_idx_nxt  = '0;
         w_byte_idx_nxt = 2'd0;
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_en      <= 1'b0;
         r_rd_addr    <= '0;
         r_data_vld   <= 1'b0;
         r_pix_idx    <= '0;
         r_byte_idx   <= 2'd0;
         r_pixel      <= 24'd0;
         r_tx_trigger <= 1'b0;
         r_tx_data    <= 8'd0;
         r_tx_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
         r_timer      <= '0;
      end else begin
         r_rd_en      <= w_rd_en_nxt;
         r_rd_addr    <= w_rd_addr_nxt;
         r_data_vld   <= r_rd_en;
         r_pix_idx    <= w_pix_idx_nxt;
         r_byte_idx   <= w_byte_idx_nxt;
         r_pixel      <= w_pixel_nxt;
         r_tx_trigger <= w_tx_trigger_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_tx_valid   <= w_tx_valid_nxt;
         r_busy       <= w_busy_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_overrun    <= w_overrun_nxt;
         r_timer      <= w_timer_nxt;
      end
   end

   assign rd_en      = r_rd_en;
   assign rd_addr    = r_rd_addr;
   assign tx_trigger = r_tx_trigger;
   assign tx_data    = r_tx_data;
   assign tx_valid   = r_tx_valid;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Randomized bench for ws2812_frame_sequencer: byte-order model, sender model, frame pacing and overrun.
// Brightness scaling is exercised when WS2812_SEQ_BRIGHTNESS_EN is defined.
module tb_ws2812_frame_sequencer;

   localparam int unsigned NUM_LEDS = 2;
   localparam int unsigned PERIOD   = 400;
   localparam int unsigned AW       = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [23:0]   rd_data;
   logic          tx_trigger;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_request;
   logic          busy;
   logic          frame_done;
   logic          overrun;
   logic [7:0]    bright_m;

   ws2812_frame_sequencer #(
      .NUM_LEDS    (NUM_LEDS),
      .FRAME_PERIOD(PERIOD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
`ifdef WS2812_SEQ_BRIGHTNESS_EN
      .brightness(bright_m),
`endif
      .tx_trigger(tx_trigger),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_request(tx_request),
      .busy      (busy),
      .frame_done(frame_done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pixel memory: read data valid the cycle after rd_en
   logic [23:0] mem [NUM_LEDS];
   initial begin
      rd_data = 24'd0;
      forever begin
         @(negedge clk);
         if (rd_en) rd_data = mem[rd_addr];
      end
   end

   // Expected k-th byte of a frame: wire order G,R,B per pixel, scaled by (bright+1)/256
   function automatic logic [7:0] exp_byte(input int k);
      logic [23:0] px;
      int          b;
      px = mem[k / 3];
      case (k % 3)
         0:       b = int'(px[15:8]);
         1:       b = int'(px[23:16]);
         default: b = int'(px[7:0]);
      endcase
      b = (b * (int'(bright_m) + 1)) / 256;
      return 8'(b);
   endfunction

   // Sender model: after a trigger, one request every snd_gap cycles until it sees no data
   int          snd_gap    = 6;
   int          snd_cnt    = 0;
   bit          snd_active = 1'b0;
   bit          snd_eod    = 1'b0;
   logic [7:0]  got_q[$];

   initial begin
      tx_request = 1'b0;
      forever begin
         @(negedge clk);
         tx_request = 1'b0;
         if (rst) begin
            snd_active = 1'b0;
            snd_eod    = 1'b0;
            got_q.delete();
         end else if (tx_trigger) begin
            snd_active = 1'b1;
            snd_cnt    = snd_gap;
         end else if (snd_active) begin
            if (snd_cnt > 1) begin
               snd_cnt--;
            end else begin
               tx_request = 1'b1;
               snd_cnt    = snd_gap;
               if (tx_valid) begin
                  got_q.push_back(tx_data);
               end else begin
                  snd_active = 1'b0;
                  snd_eod    = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: timestamps events and checks each completed frame against the model
   int cyc = 0;
   int trig_q[$];
   int fd_q[$];
   int n_ovr = 0;
   bit exp_ovr = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (tx_trigger) trig_q.push_back(cyc);
      if (overrun) n_ovr++;
      if (frame_done) begin
         fd_q.push_back(cyc);
         check("frame_len", 32'(got_q.size()), 32'(3 * NUM_LEDS));
         for (int k = 0; k < got_q.size() && k < 3 * NUM_LEDS; k++)
            check($sformatf("byte%0d", k), 32'(got_q[k]), 32'(exp_byte(k)));
         check("eod_seen", 32'(snd_eod), 32'd1);
         check("overrun_at_done", 32'(overrun), 32'(exp_ovr));
         got_q.delete();
         snd_eod = 1'b0;
      end else if (overrun) begin
         check("overrun_stray", 32'(overrun), 32'd0);
      end
   end

   task automatic wait_trig(input int n, input int budget);
      int c = 0;
      while (trig_q.size() < n && c < budget) begin @(negedge clk); c++; end
      check("wait_trigger", 32'(trig_q.size() >= n), 32'd1);
   endtask

   task automatic wait_fd(input int n, input int budget);
      int c = 0;
      while (fd_q.size() < n && c < budget) begin @(negedge clk); c++; end
      check("wait_frame_done", 32'(fd_q.size() >= n), 32'd1);
   endtask

   task automatic wait_got(input int n, input int budget);
      int c = 0;
      while (got_q.size() < n && c < budget) begin @(negedge clk); c++; end
      check("wait_bytes", 32'(got_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (busy && c < budget) begin @(negedge clk); c++; end
      check("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic new_phase();
      for (int i = 0; i < NUM_LEDS; i++) mem[i] = 24'($urandom);
      trig_q.delete();
      fd_q.delete();
      n_ovr = 0;
   endtask

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      bright_m = 8'd255;
      new_phase();
      repeat (3) @(negedge clk);
      check("rst_rd_en",      32'(rd_en),      32'd0);
      check("rst_rd_addr",    32'(rd_addr),    32'd0);
      check("rst_tx_trigger", 32'(tx_trigger), 32'd0);
      check("rst_tx_data",    32'(tx_data),    32'd0);
      check("rst_tx_valid",   32'(tx_valid),   32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_overrun",    32'(overrun),    32'd0);
      rst = 1'b0;

      // Steady frames with a fast sender: exact period, no overrun
      @(negedge clk);
`ifdef WS2812_SEQ_BRIGHTNESS_EN
      bright_m = 8'd127;
      mem[0]   = 24'hFF8040;
`endif
      snd_gap = int'($urandom_range(12, 4));
      exp_ovr = 1'b0;
      enable  = 1'b1;
      wait_trig(4, 2500);
      for (int i = 1; i < trig_q.size() && i < 4; i++)
         check("trigger_period", 32'(trig_q[i] - trig_q[i-1]), 32'(PERIOD));
      check("frames_done_p1", 32'(fd_q.size()), 32'd3);
      check("overruns_p1", 32'(n_ovr), 32'd0);

      // Drop enable during the third byte: frame completes, no further trigger
      wait_got(3, 500);
      enable = 1'b0;
      wait_fd(4, 1000);
      wait_idle(600);
      repeat (600) @(negedge clk);
      check("trigger_after_drop", 32'(trig_q.size()), 32'd4);
      check("busy_after_drop", 32'(busy), 32'd0);
      check("overruns_p2", 32'(n_ovr), 32'd0);

      // Slow sender: every frame overruns, restart 2 cycles after frame_done
      new_phase();
`ifdef WS2812_SEQ_BRIGHTNESS_EN
      bright_m = 8'($urandom);
`endif
      snd_gap = 100;
      exp_ovr = 1'b1;
      enable  = 1'b1;
      wait_fd(3, 4000);
      enable = 1'b0;
      wait_fd(4, 1500);
      wait_idle(100);
      check("overruns_p3", 32'(n_ovr), 32'd4);
      check("triggers_p3", 32'(trig_q.size()), 32'd4);
      for (int i = 0; i + 1 < trig_q.size() && i < fd_q.size(); i++)
         check("restart_gap", 32'(trig_q[i+1] - fd_q[i]), 32'd2);

      // Reset mid-stream aborts, restart reads pixel 0 first
      new_phase();
`ifdef WS2812_SEQ_BRIGHTNESS_EN
      bright_m = 8'($urandom);
`endif
      snd_gap = int'($urandom_range(10, 4));
      exp_ovr = 1'b0;
      enable  = 1'b1;
      wait_got(2, 1000);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_mid_busy",     32'(busy),     32'd0);
      check("rst_mid_rd_en",    32'(rd_en),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int c = 0;
         while (!rd_en && c < 20) begin @(negedge clk); c++; end
         check("restart_rd_en", 32'(rd_en), 32'd1);
         check("restart_rd_addr", 32'(rd_addr), 32'd0);
      end
      wait_fd(1, 1000);
      enable = 1'b0;
      wait_idle(600);
      check("frames_done_p4", 32'(fd_q.size()), 32'd1);
      check("overruns_p4", 32'(n_ovr), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Frame-level controller for the WS2812 byte sender.
- Periodically triggers the sender and walks a pixel memory of NUM_LEDS 24-bit RGB words.
- Feeds the sender one byte per data request, in WS2812 wire order G, R, B.
- Presents no byte after the last one, so the sender enters its reset/tail phase; then waits out the frame period and repeats while enabled.

Parameters:
- NUM_LEDS, 8, pixels per frame; must be at least 1.
- FRAME_PERIOD, 200000, clock cycles between successive trigger pulses (60 Hz at 12 MHz).
- ADDR_W, $clog2(NUM_LEDS) (minimum 1), pixel memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run frames while high.
- rd_en  out  1  pixel memory read strobe.
- rd_addr  out  ADDR_W  pixel index.
- rd_data  in  24  {R[23:16], G[15:8], B[7:0]}, valid exactly 1 cycle after rd_en.
- tx_trigger  out  1  one-cycle start pulse to the sender.
- tx_data  out  8  byte to the sender.
- tx_valid  out  1  tx_data valid (level).
- tx_request  in  1  sender data_request; consumes the byte on any cycle where tx_request and tx_valid are both high.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the sender sees end of data.
- overrun  out  1  one-cycle pulse when a frame outlasts FRAME_PERIOD.

Behaviour:
- Reset values: state IDLE; rd_en=0, rd_addr=0, tx_trigger=0, tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0; frame timer=0.
- A reset mid-frame aborts immediately. The sender is reset by the system separately.
- States and transitions:
  - IDLE: if enable, go to FETCH.
  - FETCH: rd_en=1, rd_addr=0, pixel index=0, byte index=0; go to LOAD.
  - LOAD: capture rd_data into the pixel register; drive tx_data=G, tx_valid=1; pulse tx_trigger this cycle; load frame timer with FRAME_PERIOD-1; go to STREAM.
  - STREAM: on consume, advance byte index 0→1→2.
    - Byte 0 → tx_data=R next cycle. Byte 1 → tx_data=B next cycle.
    - On consume of byte 2 with pixels remaining: rd_en=1, rd_addr=index+1, hold tx_valid=0 for 1 cycle. Next cycle, capture rd_data, tx_data=G, tx_valid=1.
    - On consume of byte 2 of pixel NUM_LEDS-1: tx_valid=0; go to DRAIN.
    - tx_valid and tx_data stay stable until consumed.
  - DRAIN: tx_valid=0. On tx_request, pulse frame_done, then:
    - timer already 0 → pulse overrun; go to FETCH if enable, else IDLE.
    - otherwise go to WAIT.
  - WAIT: when timer reaches 0, go to FETCH if enable, else IDLE.
- Frame timer decrements every cycle outside IDLE until 0 and saturates at 0.
- Period in steady state: tx_trigger rising edges are exactly FRAME_PERIOD cycles apart (FETCH→LOAD overhead is absorbed by the timer being loaded at LOAD with FRAME_PERIOD-1 and the 2-cycle restart).
- enable is sampled only in IDLE, DRAIN and WAIT; dropping it mid-frame completes the current frame.
- The sender takes ≥4 cycles per byte, so the 1-cycle prefetch bubble never stalls a request. A tx_request that arrives while tx_valid=0 in STREAM is a protocol violation; no recovery is required.
- rd_addr wraps to 0 only via FETCH; there is no address overflow beyond NUM_LEDS-1.

Optional Feature:
- Macro: WS2812_SEQ_BRIGHTNESS_EN.
- Enabled:
  - Adds input port brightness [7:0].
  - Sampled once in LOAD of pixel 0 and held for the whole frame.
  - Every byte is scaled: out = (byte × (brightness+1)) >> 8, computed when the pixel is captured.
  - brightness=255 gives identity.
- Disabled: port absent; bytes pass through unscaled.

Test Plan:
- NUM_LEDS=2, memory {0x112233, 0xAABBCC}, sender model → consumed bytes 0x22,0x11,0x33,0xBB,0xAA,0xCC; then one request sees tx_valid=0; frame_done pulses once.
- FRAME_PERIOD=400, enable held high → tx_trigger pulses exactly 400 cycles apart over 3 frames; overrun stays 0.
- FRAME_PERIOD=20 with a slow sender model → overrun pulses each frame; next tx_trigger comes 2 cycles after frame_done.
- enable dropped during byte 3 → frame completes all 6 bytes; busy falls after WAIT; no further tx_trigger.
- rst asserted in STREAM → next cycle tx_valid=0, busy=0, rd_en=0; a restart with enable=1 begins at rd_addr=0.
- BRIGHTNESS_EN, brightness=127, pixel 0xFF8040 → bytes 0x40,0x7F,0x20.
